// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: redirect kinds and FSM states.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RK_JUMP = 2'd0,
    RK_CALL = 2'd1,
    RK_RET  = 2'd2,
    RK_RSVD = 2'd3
  } redirect_kind_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer whose count saturates; a push when full drops the oldest.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] pop_data,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q;
  logic [PtrW:0]   count_q;
  logic [PtrW-1:0] top_idx;

  // ptr_q is the next write slot, so the newest entry sits just below it.
  assign top_idx  = ptr_q - PtrW'(1);
  assign pop_data = mem_q[top_idx];
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PtrW + 1)'(RAS_DEPTH));
  assign overflow = push && full;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (!full) count_q <= count_q + (PtrW + 1)'(1);
    end else if (pop && !empty) begin
      ptr_q   <= top_idx;
      count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with fetch handshake, redirects, RAS-backed returns, traps and alignment faults.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] redirect_link,
  input  logic            trap,
  input  logic            trap_return,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_fault,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam logic [XLEN-1:0] StepInc   = XLEN'(STEP);
  localparam logic [XLEN-1:0] AlignMask = XLEN'(STEP - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic            overflow_q, underflow_q, underflow_d;

  redirect_kind_e  kind;
  logic            ras_push, ras_pop, ras_empty, ras_full, ras_ovf;
  logic [XLEN-1:0] ras_data, target;

  assign kind = redirect_kind_e'(redirect_kind);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .push_data (redirect_link),
    .pop       (ras_pop),
    .pop_data  (ras_data),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf)
  );

  // Returns fall back to the supplied target when the stack has nothing to offer.
  assign target = (kind == RK_RET && !ras_empty) ? ras_data : redirect_target;

  assign fetch_valid = (state_q == ST_RUN) && !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap) begin
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
        end else if (trap_return) begin
          pc_d = epc_q;
        end else if (redirect_valid) begin
          ras_push    = (kind == RK_CALL);
          ras_pop     = (kind == RK_RET) && !ras_empty;
          underflow_d = (kind == RK_RET) && ras_empty;
          if ((target & AlignMask) != '0) begin
            pc_d       = TRAP_VECTOR;
            epc_d      = target;
            misalign_d = 1'b1;
          end else begin
            pc_d = target;
          end
        end else if (fetch_valid && fetch_ready) begin
          pc_d = pc_q + StepInc;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      misalign_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      misalign_q  <= misalign_d;
      overflow_q  <= ras_ovf;
      underflow_q <= underflow_d;
    end
  end

  assign pc             = pc_q;
  assign epc            = epc_q;
  assign misalign_fault = misalign_q;
  assign ras_overflow   = overflow_q;
  assign ras_underflow  = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus a randomized run against a queue-based model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, redirect_valid, trap, trap_return;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_target, redirect_link;
  logic [31:0] pc, epc;
  logic        fetch_valid, misalign_fault, ras_overflow, ras_underflow;

  int n_pass = 0;
  int n_total = 0;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .redirect_link   (redirect_link),
    .trap            (trap),
    .trap_return     (trap_return),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .epc             (epc),
    .misalign_fault  (misalign_fault),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; stall = 0; redirect_valid = 0; trap = 0; trap_return = 0;
    redirect_kind = 0; redirect_target = 0; redirect_link = 0;
  endtask

  task automatic do_reset();
    idle(); fetch_ready = 1; reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] t, input logic [31:0] l);
    redirect_valid = 1; redirect_kind = k; redirect_target = t; redirect_link = l;
    tick();
    redirect_valid = 0;
  endtask

  task automatic test_reset();
    idle(); fetch_ready = 1; reset = 1;
    tick();
    n_total++; if (pc !== 32'h0) $display("FAIL boot_pc got %h want %h", pc, 32'h0); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL boot_fv got %b want 0", fetch_valid); else n_pass++;
    n_total++; if (epc !== 32'h0) $display("FAIL boot_epc got %h want 0", epc); else n_pass++;
    reset = 0;
    tick();
    n_total++; if (fetch_valid !== 1'b0 && pc !== 32'h0) $display("FAIL boot_exit pc %h", pc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pc !== 32'(4 * i) || fetch_valid !== 1'b1)
        $display("FAIL count_%0d got pc=%h fv=%b want pc=%h fv=1", i, pc, fetch_valid, 4 * i);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(); tick();
    n_total++; if (pc !== 32'h8) $display("FAIL bp_start got %h want 8", pc); else n_pass++;
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (pc !== 32'h8 || fetch_valid !== 1'b1)
        $display("FAIL bp_hold_%0d got pc=%h fv=%b want pc=8 fv=1", i, pc, fetch_valid);
      else n_pass++;
    end
    fetch_ready = 1; stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (pc !== 32'h8 || fetch_valid !== 1'b0)
        $display("FAIL stall_hold_%0d got pc=%h fv=%b want pc=8 fv=0", i, pc, fetch_valid);
      else n_pass++;
    end
    stall = 0;
    tick();
    n_total++; if (pc !== 32'hc) $display("FAIL stall_release got %h want c", pc); else n_pass++;
  endtask

  task automatic test_call_return();
    do_reset(); fetch_ready = 0;
    redirect(2'd1, 32'h200, 32'h14);
    n_total++; if (pc !== 32'h200) $display("FAIL call_pc got %h want 200", pc); else n_pass++;
    redirect(2'd2, 32'hdead, 32'h0);
    n_total++; if (pc !== 32'h14) $display("FAIL ret_pc got %h want 14", pc); else n_pass++;
    n_total++; if (ras_underflow !== 1'b0) $display("FAIL ret_unf got %b want 0", ras_underflow); else n_pass++;
    redirect(2'd2, 32'hdeac, 32'h0);
    n_total++; if (pc !== 32'hdeac) $display("FAIL ret_empty_pc got %h want deac", pc); else n_pass++;
    n_total++; if (ras_underflow !== 1'b1) $display("FAIL ret_empty_unf got %b want 1", ras_underflow); else n_pass++;
    tick();
    n_total++; if (ras_underflow !== 1'b0) $display("FAIL unf_pulse got %b want 0", ras_underflow); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset(); fetch_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      redirect(2'd1, 32'h300, 32'(16 * i));
      n_total++;
      if (ras_overflow !== (i == 5)) $display("FAIL ovf_push_%0d got %b want %b", i, ras_overflow, i == 5);
      else n_pass++;
    end
    for (int i = 5; i >= 2; i--) begin
      redirect(2'd2, 32'h400, 32'h0);
      n_total++;
      if (pc !== 32'(16 * i) || ras_underflow !== 1'b0)
        $display("FAIL ovf_ret_%0d got pc=%h unf=%b want pc=%h unf=0", i, pc, ras_underflow, 16 * i);
      else n_pass++;
    end
    redirect(2'd2, 32'h400, 32'h0);
    n_total++;
    if (pc !== 32'h400 || ras_underflow !== 1'b1)
      $display("FAIL ovf_ret_empty got pc=%h unf=%b want pc=400 unf=1", pc, ras_underflow);
    else n_pass++;
  endtask

  task automatic test_misalign();
    do_reset(); fetch_ready = 0;
    redirect(2'd0, 32'h202, 32'h0);
    n_total++;
    if (pc !== 32'h100 || epc !== 32'h202 || misalign_fault !== 1'b1)
      $display("FAIL mis_trap got pc=%h epc=%h mf=%b want 100 202 1", pc, epc, misalign_fault);
    else n_pass++;
    tick();
    n_total++; if (misalign_fault !== 1'b0) $display("FAIL mis_pulse got %b want 0", misalign_fault); else n_pass++;
    trap_return = 1;
    tick();
    trap_return = 0;
    n_total++; if (pc !== 32'h202) $display("FAIL mis_tret got %h want 202", pc); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset(); fetch_ready = 0;
    redirect(2'd0, 32'h40, 32'h0);
    trap = 1;
    redirect(2'd1, 32'h500, 32'h99c);
    trap = 0;
    n_total++;
    if (pc !== 32'h100 || epc !== 32'h40) $display("FAIL prio_trap got pc=%h epc=%h want 100 40", pc, epc);
    else n_pass++;
    redirect(2'd2, 32'h600, 32'h0);
    n_total++;
    if (pc !== 32'h600 || ras_underflow !== 1'b1)
      $display("FAIL prio_no_push got pc=%h unf=%b want 600 1", pc, ras_underflow);
    else n_pass++;
    stall = 1; fetch_ready = 1;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; stall = 0;
    n_total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b0) $display("FAIL mid_reset got pc=%h fv=%b want 0 0", pc, fetch_valid);
    else n_pass++;
    tick();
    n_total++; if (fetch_valid !== 1'b1) $display("FAIL mid_reset_run got %b want 1", fetch_valid); else n_pass++;
  endtask

  // Behavioural model: RAS as a queue of return addresses, newest at the back.
  logic [31:0] m_pc, m_epc;
  logic        m_boot, m_mis, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_step();
    logic [31:0] t;
    m_mis = 0; m_ovf = 0; m_unf = 0;
    if (reset) begin
      m_pc = 0; m_epc = 0; m_boot = 1; m_ras.delete();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (trap) begin
      m_epc = m_pc; m_pc = 32'h100;
    end else if (trap_return) begin
      m_pc = m_epc;
    end else if (redirect_valid) begin
      t = redirect_target;
      if (redirect_kind == 2'd1) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(redirect_link);
      end else if (redirect_kind == 2'd2) begin
        if (m_ras.size() > 0) t = m_ras.pop_back();
        else m_unf = 1;
      end
      if (t % 4 != 0) begin
        m_pc = 32'h100; m_epc = t; m_mis = 1;
      end else m_pc = t;
    end else if (!stall && fetch_ready) begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic test_random();
    do_reset();
    m_pc = 0; m_epc = 0; m_boot = 0; m_ras.delete();
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(63) == 0);
      trap            = ($urandom_range(15) == 0);
      trap_return     = ($urandom_range(15) == 0);
      redirect_valid  = ($urandom_range(3) == 0);
      redirect_kind   = 2'($urandom_range(3));
      redirect_target = {$urandom_range(32'hffff), 14'h0, 2'b00};
      if ($urandom_range(7) == 0) redirect_target[1:0] = 2'($urandom_range(3));
      redirect_link   = {$urandom_range(32'hffff), 14'h0, 2'b00};
      stall           = ($urandom_range(3) == 0);
      fetch_ready     = ($urandom_range(3) != 0);
      tick();
      model_step();
      n_total++;
      if (pc !== m_pc || epc !== m_epc || fetch_valid !== (!m_boot && !stall) ||
          misalign_fault !== m_mis || ras_overflow !== m_ovf || ras_underflow !== m_unf)
        $display("FAIL rand_%0d got pc=%h epc=%h fv=%b mf=%b ov=%b un=%b want %h %h %b %b %b %b",
                 i, pc, epc, fetch_valid, misalign_fault, ras_overflow, ras_underflow,
                 m_pc, m_epc, !m_boot && !stall, m_mis, m_ovf, m_unf);
      else n_pass++;
    end
  endtask

  initial begin
    idle(); fetch_ready = 0;
    test_reset();
    test_backpressure();
    test_call_return();
    test_overflow();
    test_misalign();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
